cache_controller: RTL
=====================

# cache_controller

Two-way set-associative, write-through, no-write-allocate data cache between the ARM memory stage and `sram_controller`. It answers read hits in the same cycle. It turns read misses into one 64-bit block fetch from `sram_controller` and forwards every write to it. The CPU stalls while `ready_out` is low.

## Interface
Parameters:
- `SETS`, 64: number of sets; index width is log2(`SETS`).
- `TAG_W`, 10: tag width; address bits [16:7] for the default `SETS`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `r_en_in`  in  1  CPU read request, held until `ready_out`.
- `w_en_in`  in  1  CPU write request, held until `ready_out`.
- `address_in`  in  32  CPU word address; bit0 selects the word, [6:1] are the index, [16:7] are the tag.
- `write_data_in`  in  32  CPU write word.
- `read_data_out`  out  32  CPU read word, valid while `ready_out`=1 on a read.
- `ready_out`  out  1  transaction completes at the rising edge where this is 1.
- `sram_r_en_out`  out  1  block-read request to `sram_controller`.
- `sram_w_en_out`  out  1  word-write request to `sram_controller`.
- `sram_address_out`  out  32  word address to `sram_controller`.
- `sram_write_data_out`  out  32  write word to `sram_controller`.
- `sram_read_data_in`  in  64  fetched block: {word1, word0}.
- `sram_ready_in`  in  1  `sram_controller` done, one-cycle pulse.

## Operation
- Storage per set: two ways, each with a valid bit, `TAG_W` tag bits and 64 data bits. One LRU bit per set; LRU=w means way w is the victim.
- Hit: valid and tag match in either way. At most one way can match.
- State machine:
  - IDLE: no request, or a read hit (`ready_out`=1 combinationally).
  - READ_MISS: `sram_r_en_out`=1 with address {`address_in`[31:1],1'b0}. The block returns on `sram_ready_in`.
  - WRITE: `sram_w_en_out`=1, with address and data taken straight from the CPU request.
- Transitions:
  - IDLE→READ_MISS: `r_en_in` and miss.
  - IDLE→WRITE: `w_en_in`.
  - READ_MISS→IDLE and WRITE→IDLE: on `sram_ready_in`.
- Read hit: `read_data_out` is the selected word of the hit way. On the edge, LRU is set to the other way.
- Read miss:
  - Victim is the first invalid way (way0 first); if both ways are valid, the LRU way.
  - In the `sram_ready_in` cycle: `read_data_out` is the word of `sram_read_data_in` selected by bit0, and `ready_out`=1.
  - On that edge the victim is written (data, tag, valid=1) and LRU is set to the other way.
- Write: on the `sram_ready_in` edge, a hit way has its selected word updated and LRU touched. A miss leaves the cache unchanged (no allocate). `ready_out`=1 in the `sram_ready_in` cycle.
- Simultaneous `r_en_in` and `w_en_in` is illegal; the block treats it as a write.
- Reset: all valid and LRU bits cleared, state IDLE. A reset mid-miss or mid-write abandons the transaction, and the SRAM enables drop at that edge.

## Timing
- Reset values: all outputs 0.
- Read-hit latency: 0 cycles; `ready_out` rises in the same cycle as `r_en_in`.
- Miss and write latency: `sram_controller` latency + 1 (the IDLE decision cycle).
- `sram_r_en_out` and `sram_w_en_out` are registered from the state. They stay high until and including the `sram_ready_in` cycle, and are low the cycle after.
- `ready_out` is 0 in every cycle except the completion cycle. After completion, the requester must deassert or change its request before the next edge is sampled in IDLE.
- `sram_ready_in` arriving in IDLE is ignored.

## Structure
- Package `cache_pkg` holds:
  - the `TAG_W`, `INDEX_W` and `SETS` constants;
  - the state enum (IDLE, READ_MISS, WRITE);
  - the address-field slicing functions (tag, index, word select).
- Sub-module `cache_set_array` holds the valid, tag, data and LRU arrays. It provides a combinational lookup (hit, hit_way, data, victim) and synchronous fill, word-update and LRU-touch ports. `cache_controller` holds the FSM and the muxing.

## Test plan
- Cold read at 0x0000 with SRAM holding {0x7788_5566, 0x3344_1122}:
  - one `sram_r_en_out` burst at address 0;
  - `read_data_out`=0x3344_1122 with `ready_out` in the `sram_ready_in` cycle.
- Read 0x0001 after that fill: hit, `ready_out` in the same cycle, data 0x7788_5566, and no SRAM activity.
- Write 0x0001 ← 0xAABB_CCDD:
  - `sram_w_en_out` with address 0x0001 and that data;
  - a following read of 0x0001 hits and returns 0xAABB_CCDD.
- Write a miss to 0x0080 ← 0x1, then read 0x0080: the read misses (no allocate) and fetches from SRAM.
- Fill 0x0000, then 0x0080, read 0x0000 again, then read 0x0100 (all set 0):
  - 0x0100 evicts the 0x0080 block;
  - a later read of 0x0000 hits and a later read of 0x0080 misses.
- Assert `rst` while in READ_MISS:
  - next cycle `sram_r_en_out`=0 and state is IDLE;
  - a read of 0x0000 then misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the
// two-way write-through data cache.
package cache_pkg;

  localparam int SETS    = 64;
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_MISS = 2'd1,
    ST_WRITE     = 2'd2
  } state_t;

  // Word address layout: [0] word select, [index_w:1] index, tag above it.
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
    return (addr >> 1) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w,
                                           input int tag_w);
    return (addr >> (index_w + 1)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

  function automatic logic addr_word(input logic [31:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/cache_set_array.sv
// Two-way tag/data store with per-set LRU: combinational lookup plus
// synchronous fill, word-update and LRU-touch ports sharing one index.
module cache_set_array #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10,
  localparam int INDEX_W = $clog2(SETS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] i_index,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic               i_word,
  output logic               o_hit,
  output logic               o_hit_way,
  output logic [31:0]        o_hit_word,
  output logic               o_victim,
  input  logic               i_fill_en,
  input  logic               i_fill_way,
  input  logic [63:0]        i_fill_data,
  input  logic               i_upd_en,
  input  logic               i_upd_way,
  input  logic [31:0]        i_upd_data,
  input  logic               i_touch_en,
  input  logic               i_touch_way
);

  logic [SETS-1:0]  r_valid0, r_valid1, r_lru;
  logic [TAG_W-1:0] r_tag0  [SETS];
  logic [TAG_W-1:0] r_tag1  [SETS];
  logic [63:0]      r_data0 [SETS];
  logic [63:0]      r_data1 [SETS];

  logic        w_hit0, w_hit1;
  logic [63:0] w_blk;

  assign w_hit0     = r_valid0[i_index] && (r_tag0[i_index] == i_tag);
  assign w_hit1     = r_valid1[i_index] && (r_tag1[i_index] == i_tag);
  assign o_hit      = w_hit0 | w_hit1;
  assign o_hit_way  = w_hit1;
  assign w_blk      = w_hit1 ? r_data1[i_index] : r_data0[i_index];
  assign o_hit_word = i_word ? w_blk[63:32] : w_blk[31:0];
  // Fill an empty way before evicting anything; way0 is preferred.
  assign o_victim   = !r_valid0[i_index] ? 1'b0 :
                      (!r_valid1[i_index] ? 1'b1 : r_lru[i_index]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else begin
      if (i_fill_en) begin
        if (i_fill_way) r_valid1[i_index] <= 1'b1;
        else            r_valid0[i_index] <= 1'b1;
      end
      if (i_touch_en) r_lru[i_index] <= ~i_touch_way;
    end
  end

  // Tags and data need no reset: they are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (i_fill_en && !i_fill_way) begin
      r_tag0[i_index]  <= i_tag;
      r_data0[i_index] <= i_fill_data;
    end
    if (i_fill_en && i_fill_way) begin
      r_tag1[i_index]  <= i_tag;
      r_data1[i_index] <= i_fill_data;
    end
    if (i_upd_en && !i_upd_way) begin
      if (i_word) r_data0[i_index][63:32] <= i_upd_data;
      else        r_data0[i_index][31:0]  <= i_upd_data;
    end
    if (i_upd_en && i_upd_way) begin
      if (i_word) r_data1[i_index][63:32] <= i_upd_data;
      else        r_data1[i_index][31:0]  <= i_upd_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache
// between the CPU memory stage and the SRAM controller.
module cache_controller #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_en_in,
  input  logic        w_en_in,
  input  logic [31:0] address_in,
  input  logic [31:0] write_data_in,
  output logic [31:0] read_data_out,
  output logic        ready_out,
  output logic        sram_r_en_out,
  output logic        sram_w_en_out,
  output logic [31:0] sram_address_out,
  output logic [31:0] sram_write_data_out,
  input  logic [63:0] sram_read_data_in,
  input  logic        sram_ready_in,
  output logic [1:0]  dbg_state_out
);
  import cache_pkg::state_t;
  import cache_pkg::ST_IDLE;
  import cache_pkg::ST_READ_MISS;
  import cache_pkg::ST_WRITE;
  import cache_pkg::addr_index;
  import cache_pkg::addr_tag;
  import cache_pkg::addr_word;

  localparam int INDEX_W = $clog2(SETS);

  state_t      r_state;
  logic        r_sram_r_en, r_sram_w_en;
  logic [31:0] r_sram_addr, r_sram_wdata;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_word;
  logic               w_hit, w_hit_way, w_victim;
  logic [31:0]        w_hit_word, w_sram_word;
  logic               w_rd_hit, w_done, w_fill_en, w_upd_en, w_touch_en, w_touch_way;

  assign w_index = INDEX_W'(addr_index(address_in, INDEX_W));
  assign w_tag   = TAG_W'(addr_tag(address_in, INDEX_W, TAG_W));
  assign w_word  = addr_word(address_in);

  // A request with both enables set is handled as a write.
  assign w_rd_hit    = !rst && (r_state == ST_IDLE) && r_en_in && !w_en_in && w_hit;
  assign w_done      = !rst && (r_state != ST_IDLE) && sram_ready_in;
  assign w_fill_en   = w_done && (r_state == ST_READ_MISS);
  assign w_upd_en    = w_done && (r_state == ST_WRITE) && w_hit;
  assign w_touch_en  = w_rd_hit | w_fill_en | w_upd_en;
  assign w_touch_way = w_fill_en ? w_victim : w_hit_way;
  assign w_sram_word = w_word ? sram_read_data_in[63:32] : sram_read_data_in[31:0];

  cache_set_array #(.SETS(SETS), .TAG_W(TAG_W)) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_index     (w_index),
    .i_tag       (w_tag),
    .i_word      (w_word),
    .o_hit       (w_hit),
    .o_hit_way   (w_hit_way),
    .o_hit_word  (w_hit_word),
    .o_victim    (w_victim),
    .i_fill_en   (w_fill_en),
    .i_fill_way  (w_victim),
    .i_fill_data (sram_read_data_in),
    .i_upd_en    (w_upd_en),
    .i_upd_way   (w_hit_way),
    .i_upd_data  (write_data_in),
    .i_touch_en  (w_touch_en),
    .i_touch_way (w_touch_way)
  );

  assign ready_out     = w_rd_hit | w_done;
  assign read_data_out = w_rd_hit  ? w_hit_word :
                         w_fill_en ? w_sram_word : 32'd0;

  assign sram_r_en_out       = r_sram_r_en;
  assign sram_w_en_out       = r_sram_w_en;
  assign sram_address_out    = r_sram_addr;
  assign sram_write_data_out = r_sram_wdata;
  assign dbg_state_out       = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sram_r_en  <= 1'b0;
      r_sram_w_en  <= 1'b0;
      r_sram_addr  <= 32'd0;
      r_sram_wdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_en_in) begin
            r_state      <= ST_WRITE;
            r_sram_w_en  <= 1'b1;
            r_sram_addr  <= address_in;
            r_sram_wdata <= write_data_in;
          end else if (r_en_in && !w_hit) begin
            r_state     <= ST_READ_MISS;
            r_sram_r_en <= 1'b1;
            r_sram_addr <= {address_in[31:1], 1'b0};
          end
        end
        ST_READ_MISS, ST_WRITE: begin
          if (sram_ready_in) begin
            r_state     <= ST_IDLE;
            r_sram_r_en <= 1'b0;
            r_sram_w_en <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
